// File: rtl/p405s_dvcevent_pkg.sv
// Shared definitions for the data-value-compare event stage:
// DVC compare mode encodings and the fixed byte-lane count.
package p405s_dvcevent_pkg;

  localparam int DVC_BYTES = 4;

  typedef enum logic [1:0] {
    DVM_OFF  = 2'b00,
    DVM_ALL  = 2'b01,
    DVM_ANY  = 2'b10,
    DVM_HALF = 2'b11
  } dvcMode_t;

endpackage

// File: rtl/p405s_dvcReduce.sv
// Reduces one channel's per-byte DVC compare vector to a single match
// according to the programmed compare mode. Purely combinational.
module p405s_dvcReduce
  import p405s_dvcevent_pkg::*;
(
  input  logic [0:DVC_BYTES-1] byteCmp,
  input  logic [0:DVC_BYTES-1] byteEn,
  input  dvcMode_t             mode,
  output logic                 match
);

  logic [0:DVC_BYTES-1] byteOk;

  // A lane that does not take part in the access cannot veto a match.
  assign byteOk = byteCmp | ~byteEn;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    match = 1'b0;
    unique case (mode)
      DVM_OFF:  match = 1'b0;
      DVM_ALL:  match = (&byteOk) & (|byteEn);
      DVM_ANY:  match = |byteCmp;
      DVM_HALF: match = (byteOk[0] & byteOk[1] & (byteEn[0] | byteEn[1])) |
                        (byteOk[2] & byteOk[3] & (byteEn[2] | byteEn[3]));
      default:  match = 1'b0;
    endcase
  end

endmodule

// File: rtl/p405s_dvcevent.sv
// DVC event stage: qualifies both compare channels in EXE, carries them through
// the EXE->WB register, and drives sticky DBSR status plus a one-shot debug request.
module p405s_dvcevent
  import p405s_dvcevent_pkg::*;
(
  input  logic             CB,
  input  logic             resetCore,
  input  logic [0:3]       EXE_dvc1ByteCmp,
  input  logic [0:3]       EXE_dvc2ByteCmp,
  input  logic [0:3]       PCL_dvcByteEnL2,
  input  logic             EXE_dac1Match,
  input  logic             EXE_dac2Match,
  input  logic             EXE_ldStValid,
  input  logic             PCL_exeHold,
  input  logic             PCL_wbFlush,
  input  logic [0:1]       DBCR_dv1m,
  input  logic [0:1]       DBCR_dv2m,
  input  logic             DBSR_clrDvc1,
  input  logic             DBSR_clrDvc2,
  output logic             WB_dvc1Event,
  output logic             WB_dvc2Event,
  output logic             DBSR_dvc1Sts,
  output logic             DBSR_dvc2Sts,
  output logic             DVC_debugReq
);

  logic dvc1Match, dvc2Match;
  logic exeHit1, exeHit2;
  logic wbEvent1, wbEvent2;
  logic sts1, sts2;
  logic debugReq;
  logic reported;
  logic wbLive1, wbLive2, wbAnyLive;

  p405s_dvcReduce u_reduce1 (
    .byteCmp (EXE_dvc1ByteCmp),
    .byteEn  (PCL_dvcByteEnL2),
    .mode    (dvcMode_t'(DBCR_dv1m)),
    .match   (dvc1Match)
  );

  p405s_dvcReduce u_reduce2 (
    .byteCmp (EXE_dvc2ByteCmp),
    .byteEn  (PCL_dvcByteEnL2),
    .mode    (dvcMode_t'(DBCR_dv2m)),
    .match   (dvc2Match)
  );

  assign exeHit1 = dvc1Match & EXE_dac1Match & EXE_ldStValid;
  assign exeHit2 = dvc2Match & EXE_dac2Match & EXE_ldStValid;

  // A WB event being flushed this cycle must not reach status or request.
  assign wbLive1   = wbEvent1 & ~PCL_wbFlush;
  assign wbLive2   = wbEvent2 & ~PCL_wbFlush;
  assign wbAnyLive = wbLive1 | wbLive2;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      wbEvent1 <= 1'b0;
      wbEvent2 <= 1'b0;
    end else if (PCL_wbFlush) begin
      wbEvent1 <= 1'b0;
      wbEvent2 <= 1'b0;
    end else if (!PCL_exeHold) begin
      wbEvent1 <= exeHit1;
      wbEvent2 <= exeHit2;
    end
  end

  // Set has priority over the mtspr clear so a coincident event is never lost.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      sts1 <= 1'b0;
      sts2 <= 1'b0;
    end else begin
      if (wbLive1)           sts1 <= 1'b1;
      else if (DBSR_clrDvc1) sts1 <= 1'b0;
      if (wbLive2)           sts2 <= 1'b1;
      else if (DBSR_clrDvc2) sts2 <= 1'b0;
    end
  end

  // The "reported" flag survives only while WB is held, so a held event
  // requests once while each freshly loaded event requests again.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      debugReq <= 1'b0;
      reported <= 1'b0;
    end else begin
      debugReq <= wbAnyLive & ~reported;
      if (PCL_wbFlush || !PCL_exeHold) reported <= 1'b0;
      else                             reported <= reported | wbAnyLive;
    end
  end

  assign WB_dvc1Event = wbEvent1;
  assign WB_dvc2Event = wbEvent2;
  assign DBSR_dvc1Sts = sts1;
  assign DBSR_dvc2Sts = sts2;
  assign DVC_debugReq = debugReq;

endmodule

// File: tb/tb_p405s_dvcevent.sv
// Directed self-checking bench for p405s_dvcevent: compare modes, flush,
// hold, sticky status set/clear priority and reset during a held event.
module tb_p405s_dvcevent;

  logic       CB;
  logic       resetCore;
  logic [0:3] EXE_dvc1ByteCmp;
  logic [0:3] EXE_dvc2ByteCmp;
  logic [0:3] PCL_dvcByteEnL2;
  logic       EXE_dac1Match;
  logic       EXE_dac2Match;
  logic       EXE_ldStValid;
  logic       PCL_exeHold;
  logic       PCL_wbFlush;
  logic [0:1] DBCR_dv1m;
  logic [0:1] DBCR_dv2m;
  logic       DBSR_clrDvc1;
  logic       DBSR_clrDvc2;
  logic       WB_dvc1Event;
  logic       WB_dvc2Event;
  logic       DBSR_dvc1Sts;
  logic       DBSR_dvc2Sts;
  logic       DVC_debugReq;

  int nCmp = 0;
  int nErr = 0;
  int reqPulses;

  p405s_dvcevent dut (
    .CB              (CB),
    .resetCore       (resetCore),
    .EXE_dvc1ByteCmp (EXE_dvc1ByteCmp),
    .EXE_dvc2ByteCmp (EXE_dvc2ByteCmp),
    .PCL_dvcByteEnL2 (PCL_dvcByteEnL2),
    .EXE_dac1Match   (EXE_dac1Match),
    .EXE_dac2Match   (EXE_dac2Match),
    .EXE_ldStValid   (EXE_ldStValid),
    .PCL_exeHold     (PCL_exeHold),
    .PCL_wbFlush     (PCL_wbFlush),
    .DBCR_dv1m       (DBCR_dv1m),
    .DBCR_dv2m       (DBCR_dv2m),
    .DBSR_clrDvc1    (DBSR_clrDvc1),
    .DBSR_clrDvc2    (DBSR_clrDvc2),
    .WB_dvc1Event    (WB_dvc1Event),
    .WB_dvc2Event    (WB_dvc2Event),
    .DBSR_dvc1Sts    (DBSR_dvc1Sts),
    .DBSR_dvc2Sts    (DBSR_dvc2Sts),
    .DVC_debugReq    (DVC_debugReq)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge CB);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic w1, input logic w2,
                        input logic s1, input logic s2, input logic rq);
    chk({tag, ".wb1"}, WB_dvc1Event, w1);
    chk({tag, ".wb2"}, WB_dvc2Event, w2);
    chk({tag, ".sts1"}, DBSR_dvc1Sts, s1);
    chk({tag, ".sts2"}, DBSR_dvc2Sts, s2);
    chk({tag, ".req"}, DVC_debugReq, rq);
  endtask

  task automatic idle();
    EXE_dvc1ByteCmp = 4'b0000;
    EXE_dvc2ByteCmp = 4'b0000;
    PCL_dvcByteEnL2 = 4'b0000;
    EXE_dac1Match   = 1'b0;
    EXE_dac2Match   = 1'b0;
    EXE_ldStValid   = 1'b0;
  endtask

  // Full-word DVC1 hit in mode 01.
  task automatic hit1();
    PCL_dvcByteEnL2 = 4'b1111;
    EXE_dvc1ByteCmp = 4'b1111;
    EXE_dac1Match   = 1'b1;
    EXE_ldStValid   = 1'b1;
  endtask

  initial begin
    idle();
    resetCore    = 1'b1;
    PCL_exeHold  = 1'b0;
    PCL_wbFlush  = 1'b0;
    DBCR_dv1m    = 2'b01;
    DBCR_dv2m    = 2'b00;
    DBSR_clrDvc1 = 1'b0;
    DBSR_clrDvc2 = 1'b0;
    step();
    step();
    chkAll("reset", 0, 0, 0, 0, 0);
    resetCore = 1'b0;
    step();
    chkAll("postReset", 0, 0, 0, 0, 0);

    // Mode 01: all enabled bytes equal -> event, then status and request.
    hit1();
    step();
    chkAll("all.t1", 1, 0, 0, 0, 0);
    idle();
    step();
    chkAll("all.t2", 0, 0, 1, 0, 1);
    step();
    chk("all.reqOnce", DVC_debugReq, 1'b0);
    DBSR_clrDvc1 = 1'b1;
    step();
    chk("all.clr", DBSR_dvc1Sts, 1'b0);
    DBSR_clrDvc1 = 1'b0;

    // Mode 01 with one byte mismatching -> nothing.
    hit1();
    EXE_dvc1ByteCmp = 4'b1110;
    step();
    chk("allMiss.wb1", WB_dvc1Event, 1'b0);
    idle();
    step();
    chkAll("allMiss.t2", 0, 0, 0, 0, 0);

    // Full compare but no DAC1 address hit -> nothing.
    hit1();
    EXE_dac1Match = 1'b0;
    step();
    chk("noDac.wb1", WB_dvc1Event, 1'b0);

    // Mode 11 on channel 2: lower halfword enabled and equal -> event.
    DBCR_dv2m = 2'b11;
    idle();
    PCL_dvcByteEnL2 = 4'b0011;
    EXE_dvc2ByteCmp = 4'b0011;
    EXE_dac2Match   = 1'b1;
    EXE_ldStValid   = 1'b1;
    step();
    chkAll("half.t1", 0, 1, 0, 0, 0);
    idle();
    step();
    chkAll("half.t2", 0, 0, 0, 1, 1);
    DBSR_clrDvc2 = 1'b1;
    step();
    chk("half.clr", DBSR_dvc2Sts, 1'b0);
    DBSR_clrDvc2 = 1'b0;

    // Mode 11: upper half enabled but only one byte equal, lower half unused -> no event.
    PCL_dvcByteEnL2 = 4'b1100;
    EXE_dvc2ByteCmp = 4'b0100;
    EXE_dac2Match   = 1'b1;
    EXE_ldStValid   = 1'b1;
    step();
    chk("halfMiss.wb2", WB_dvc2Event, 1'b0);

    // Mode 10 with the same vector: any equal byte -> event.
    DBCR_dv2m = 2'b10;
    step();
    chk("any.wb2", WB_dvc2Event, 1'b1);
    idle();
    step();
    chkAll("any.t2", 0, 0, 0, 1, 1);
    DBSR_clrDvc2 = 1'b1;
    step();
    DBSR_clrDvc2 = 1'b0;
    chk("any.clr", DBSR_dvc2Sts, 1'b0);

    // Flush coincident with the EXE hit: discarded.
    hit1();
    PCL_wbFlush = 1'b1;
    step();
    PCL_wbFlush = 1'b0;
    idle();
    chkAll("flushExe.t1", 0, 0, 0, 0, 0);
    step();
    chkAll("flushExe.t2", 0, 0, 0, 0, 0);

    // Flush while the event sits in WB: no status, no request.
    hit1();
    step();
    chk("flushWb.wb1", WB_dvc1Event, 1'b1);
    idle();
    PCL_wbFlush = 1'b1;
    step();
    PCL_wbFlush = 1'b0;
    chkAll("flushWb.t2", 0, 0, 0, 0, 0);
    step();
    chkAll("flushWb.t3", 0, 0, 0, 0, 0);

    // Hit then hold for three cycles: WB stays up four cycles, one request.
    hit1();
    step();
    chkAll("hold.c1", 1, 0, 0, 0, 0);
    idle();
    PCL_exeHold = 1'b1;
    reqPulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.wb1", WB_dvc1Event, 1'b1);
      chk("hold.sts1", DBSR_dvc1Sts, 1'b1);
      if (DVC_debugReq === 1'b1) reqPulses++;
    end
    PCL_exeHold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("holdEnd.wb1", WB_dvc1Event, 1'b0);
      if (DVC_debugReq === 1'b1) reqPulses++;
    end
    chk("hold.onePulse", (reqPulses == 1), 1'b1);

    // Status already set; clear coincident with a new WB event -> set wins.
    hit1();
    step();
    idle();
    DBSR_clrDvc1 = 1'b1;
    step();
    chk("setWins.sts1", DBSR_dvc1Sts, 1'b1);
    chk("setWins.req", DVC_debugReq, 1'b1);
    step();
    chk("clrAlone.sts1", DBSR_dvc1Sts, 1'b0);
    DBSR_clrDvc1 = 1'b0;
    step();
    chkAll("quiet", 0, 0, 0, 0, 0);

    // Reset while an unreported event is held: everything clears, no request later.
    hit1();
    step();
    chk("rstHold.wb1", WB_dvc1Event, 1'b1);
    idle();
    PCL_exeHold = 1'b1;
    resetCore   = 1'b1;
    step();
    chkAll("rstHold.t1", 0, 0, 0, 0, 0);
    resetCore   = 1'b0;
    PCL_exeHold = 1'b0;
    step();
    chkAll("rstHold.t2", 0, 0, 0, 0, 0);
    step();
    chkAll("rstHold.t3", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
